// File: rtl/route_ctl_if.sv
// rtl/route_ctl_if.sv - flit in/out, decrement-stage and allocator signals of one router input port
interface route_ctl_if #(
    parameter int DW = 32
);
    logic          in_vld;
    logic [1:0]    in_ftype;
    logic [DW-1:0] in_data;
    logic          in_rdy;
    logic [7:0]    dec_x;
    logic [7:0]    dec_y;
    logic [7:0]    dec_xd;
    logic [7:0]    dec_yd;
    logic [4:0]    out_req;
    logic [4:0]    out_gnt;
    logic          out_vld;
    logic [1:0]    out_ftype;
    logic [DW-1:0] out_data;
    logic          out_rdy;
    logic          err;

    modport slave (
        input  in_vld, in_ftype, in_data, dec_xd, dec_yd, out_gnt, out_rdy,
        output in_rdy, dec_x, dec_y, out_req, out_vld, out_ftype, out_data, err
    );

    modport master (
        output in_vld, in_ftype, in_data, dec_xd, dec_yd, out_gnt, out_rdy,
        input  in_rdy, dec_x, dec_y, out_req, out_vld, out_ftype, out_data, err
    );
endinterface

// File: rtl/route_ctl.sv
// rtl/route_ctl.sv - input-port XY routing controller: 2-entry flit FIFO, head rewrite, wormhole hold
module route_ctl #(
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    route_ctl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_FWD} state_t;

    state_t        state_q, state_d;
    logic [4:0]    req_q, req_d;
    logic [15:0]   hdr_q, hdr_d;
    logic          first_q, first_d;
    logic [DW+1:0] mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q, count_d;

    logic [DW+1:0] front;
    logic [1:0]    front_t;
    logic [DW-1:0] front_d;
    logic          nonempty;
    logic          push, pop;
    logic          vld;
    logic          err;
    logic [4:0]    route;

    assign front    = mem_q[rd_ptr_q];
    assign front_t  = front[DW+1:DW];
    assign front_d  = front[DW-1:0];
    assign nonempty = (count_q != 2'd0);
    assign push     = bus.in_vld && (count_q != 2'd2);

    // XY order: exhaust X hops first, then Y, then eject locally
    always_comb begin
        route = 5'b00001;
        if (front_d[7:0] != 8'd0) begin
            route = front_d[16] ? 5'b10000 : 5'b00100;
        end else if (front_d[15:8] != 8'd0) begin
            route = front_d[17] ? 5'b01000 : 5'b00010;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        hdr_d   = hdr_q;
        first_d = first_q;
        pop     = 1'b0;
        err     = 1'b0;
        vld     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (nonempty) begin
                    if (front_t[0]) begin
                        req_d   = route;
                        hdr_d   = (route == 5'b00001) ? front_d[15:0] : {bus.dec_yd, bus.dec_xd};
                        first_d = 1'b1;
                        state_d = S_ROUTE;
                    end else begin
                        pop = 1'b1;
                        err = 1'b1;
                    end
                end
            end
            S_ROUTE: begin
                if ((bus.out_gnt & req_q) != 5'b00000) begin
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                vld = nonempty;
                if (vld && bus.out_rdy) begin
                    pop     = 1'b1;
                    first_d = 1'b0;
                    // tail or single closes the wormhole and frees the output port
                    if (front_t[1]) begin
                        state_d = S_IDLE;
                        req_d   = 5'b00000;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_q    <= 5'b00000;
            hdr_q    <= 16'd0;
            first_q  <= 1'b0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            hdr_q   <= hdr_d;
            first_q <= first_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.in_ftype, bus.in_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bus.in_rdy    = (count_q != 2'd2);
    assign bus.dec_x     = nonempty ? front_d[7:0] : 8'd0;
    assign bus.dec_y     = nonempty ? front_d[15:8] : 8'd0;
    assign bus.out_req   = req_q;
    assign bus.out_vld   = vld;
    assign bus.out_ftype = vld ? front_t : 2'b00;
    assign bus.out_data  = !vld ? '0 : (first_q ? {front_d[DW-1:16], hdr_q} : front_d);
    assign bus.err       = err;
endmodule

// File: tb/tb_route_ctl.sv
// tb/tb_route_ctl.sv - self-checking bench for route_ctl with a flit-stream reference model
module tb_route_ctl;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    t;
        logic [DW-1:0] d;
    } flit_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    route_ctl_if #(.DW(DW)) bus ();
    route_ctl #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // decrement stage; returns junk when nothing is left to decrement
    always_comb begin
        bus.dec_xd = bus.dec_x;
        bus.dec_yd = bus.dec_y;
        if (bus.dec_x != 8'd0) begin
            bus.dec_xd = bus.dec_x - 8'd1;
        end else if (bus.dec_y != 8'd0) begin
            bus.dec_yd = bus.dec_y - 8'd1;
        end else begin
            bus.dec_xd = 8'hA5;
            bus.dec_yd = 8'h5A;
        end
    end

    int checks = 0;
    int errors = 0;

    flit_t      stim_q[$];
    flit_t      exp_q[$];
    flit_t      got_q[$];
    logic [4:0] expr_q[$];
    logic [4:0] gotr_q[$];
    int         exp_err;
    int         err_seen;
    bit         drv_done;

    function automatic logic [4:0] model_route(input logic [DW-1:0] d);
        int x = int'(d[7:0]);
        int y = int'(d[15:8]);
        if (x > 0) return d[16] ? 5'd16 : 5'd4;
        if (y > 0) return d[17] ? 5'd8 : 5'd2;
        return 5'd1;
    endfunction

    function automatic logic [DW-1:0] model_hdr(input logic [DW-1:0] d);
        int x = int'(d[7:0]);
        int y = int'(d[15:8]);
        logic [DW-1:0] r = d;
        if (x > 0) x--;
        else if (y > 0) y--;
        r[7:0]  = x[7:0];
        r[15:8] = y[7:0];
        return r;
    endfunction

    function automatic logic [DW-1:0] mk_head(input int x, input int y, input bit xd, input bit yd);
        logic [DW-1:0] d;
        d       = DW'($urandom);
        d[7:0]  = 8'(x);
        d[15:8] = 8'(y);
        d[16]   = xd;
        d[17]   = yd;
        return d;
    endfunction

    // packet-level view: each head/single opens a packet on one port, tail closes it, strays are dropped
    task automatic build_expected();
        bit         in_pkt = 0;
        logic [4:0] r = 5'd0;
        flit_t      g;
        exp_q.delete();
        expr_q.delete();
        exp_err = 0;
        foreach (stim_q[i]) begin
            if (!in_pkt) begin
                if (stim_q[i].t == 2'b01 || stim_q[i].t == 2'b11) begin
                    r   = model_route(stim_q[i].d);
                    g.t = stim_q[i].t;
                    g.d = model_hdr(stim_q[i].d);
                    exp_q.push_back(g);
                    expr_q.push_back(r);
                    in_pkt = (stim_q[i].t == 2'b01);
                end else begin
                    exp_err++;
                end
            end else begin
                exp_q.push_back(stim_q[i]);
                expr_q.push_back(r);
                if (stim_q[i].t[1]) in_pkt = 0;
            end
        end
    endtask

    task automatic gen_stream(input int npkt, input bit strays);
        flit_t f;
        int    nb;
        stim_q.delete();
        for (int p = 0; p < npkt; p++) begin
            if (strays && $urandom_range(0, 3) == 0) begin
                f.t = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b10;
                f.d = DW'($urandom);
                stim_q.push_back(f);
            end
            f.d = mk_head($urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                f.t = 2'b11;
                stim_q.push_back(f);
            end else begin
                f.t = 2'b01;
                stim_q.push_back(f);
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) begin
                    f.t = 2'b00;
                    f.d = DW'($urandom);
                    stim_q.push_back(f);
                end
                f.t = 2'b10;
                f.d = DW'($urandom);
                stim_q.push_back(f);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.out_gnt = 5'b00000;
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_flits(input bit rand_gap);
        bit r;
        foreach (stim_q[i]) begin
            if (rand_gap) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_vld   = 1'b1;
            bus.in_ftype = stim_q[i].t;
            bus.in_data  = stim_q[i].d;
            for (int k = 0; k < 500; k++) begin
                r = bus.in_rdy;
                @(posedge clk);
                #1;
                if (r) break;
            end
            bus.in_vld = 1'b0;
        end
        drv_done = 1'b1;
    endtask

    task automatic sink(input bit rand_rdy, input bit rand_gnt, output bit tmo);
        int    extra = 0;
        flit_t f;
        tmo = 1'b1;
        got_q.delete();
        gotr_q.delete();
        err_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.out_gnt = rand_gnt ? 5'($urandom_range(0, 31)) : 5'b11111;
            #1;
            if (bus.err) err_seen++;
            if (bus.out_vld && bus.out_rdy) begin
                f.t = bus.out_ftype;
                f.d = bus.out_data;
                got_q.push_back(f);
                gotr_q.push_back(bus.out_req);
            end
            if (drv_done && got_q.size() >= exp_q.size()) begin
                extra++;
                if (extra > 12) begin
                    tmo = 1'b0;
                    break;
                end
            end
        end
        bus.out_rdy = 1'b1;
        bus.out_gnt = 5'b00000;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_vld   = 1'b0;
        bus.in_ftype = 2'b00;
        bus.in_data  = '0;
        bus.out_gnt  = 5'b00000;
        bus.out_rdy  = 1'b1;
        #1;
        checks++;
        if ({bus.in_rdy, bus.out_vld, bus.out_req, bus.err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/req/err %b expected 10000000",
                     {bus.in_rdy, bus.out_vld, bus.out_req, bus.err});
        end
        checks++;
        if ({bus.out_ftype, bus.out_data, bus.dec_x, bus.dec_y} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ftype %0h data %0h dec_x %0h dec_y %0h expected all 0",
                     bus.out_ftype, bus.out_data, bus.dec_x, bus.dec_y);
        end
        apply_reset();
    endtask

    task automatic test_packet();
        logic [DW-1:0] hd, bd, td, hx;
        apply_reset();
        hd = mk_head(3, 2, 1'b0, 1'b0);
        bd = DW'($urandom);
        td = DW'($urandom);
        hx = hd;
        hx[7:0] = 8'd2;
        bus.in_vld = 1'b1; bus.in_ftype = 2'b01; bus.in_data = hd;
        @(posedge clk); #1;
        checks++;
        if (bus.out_req !== 5'b00000 || bus.dec_x !== 8'd3 || bus.dec_y !== 8'd2) begin
            errors++;
            $display("FAIL pkt_idle: got req %b dec %0d/%0d expected 00000 3/2", bus.out_req, bus.dec_x, bus.dec_y);
        end
        bus.in_ftype = 2'b00; bus.in_data = bd;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_req !== 5'b00100 || bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL pkt_req: got req %b vld %b rdy %b expected 00100 0 0", bus.out_req, bus.out_vld, bus.in_rdy);
        end
        bus.out_gnt = 5'b00100;
        @(posedge clk); #1;
        bus.out_gnt = 5'b00000;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_ftype !== 2'b01 || bus.out_data !== hx) begin
            errors++;
            $display("FAIL pkt_head: got vld %b type %b data %0h expected 1 01 %0h", bus.out_vld, bus.out_ftype, bus.out_data, hx);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_ftype !== 2'b00 || bus.out_data !== bd) begin
            errors++;
            $display("FAIL pkt_body: got vld %b type %b data %0h expected 1 00 %0h", bus.out_vld, bus.out_ftype, bus.out_data, bd);
        end
        bus.in_vld = 1'b1; bus.in_ftype = 2'b10; bus.in_data = td;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_ftype !== 2'b10 || bus.out_data !== td || bus.out_req !== 5'b00100) begin
            errors++;
            $display("FAIL pkt_tail: got type %b data %0h req %b expected 10 %0h 00100", bus.out_ftype, bus.out_data, bus.out_req, td);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_req !== 5'b00000 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL pkt_release: got req %b vld %b expected 00000 0", bus.out_req, bus.out_vld);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] a, ax, b;
        apply_reset();
        bus.out_gnt = 5'b11111;
        a = mk_head(0, 1, 1'b0, 1'b1);
        ax = a;
        ax[15:0] = 16'd0;
        b = mk_head(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        bus.in_vld = 1'b1; bus.in_ftype = 2'b11; bus.in_data = a;
        @(posedge clk); #1;
        bus.in_data = b;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_req !== 5'b01000 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_req_s: got req %b vld %b expected 01000 0", bus.out_req, bus.out_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_ftype !== 2'b11 || bus.out_data !== ax) begin
            errors++;
            $display("FAIL single_data_s: got vld %b type %b data %0h expected 1 11 %0h", bus.out_vld, bus.out_ftype, bus.out_data, ax);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_req !== 5'b00000 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got req %b vld %b expected 00000 0", bus.out_req, bus.out_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_req !== 5'b00001) begin
            errors++;
            $display("FAIL single_req_l: got req %b expected 00001", bus.out_req);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== b) begin
            errors++;
            $display("FAIL single_data_l: got vld %b data %0h expected 1 %0h", bus.out_vld, bus.out_data, b);
        end
        @(posedge clk); #1;
        bus.out_gnt = 5'b00000;
        checks++;
        if (bus.out_req !== 5'b00000) begin
            errors++;
            $display("FAIL single_done: got req %b expected 00000", bus.out_req);
        end
    endtask

    task automatic test_err();
        logic [DW-1:0] h, hx;
        apply_reset();
        bus.out_gnt = 5'b11111;
        bus.in_vld = 1'b1; bus.in_ftype = 2'b00; bus.in_data = DW'($urandom);
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err %b vld %b expected 1 0", bus.err, bus.out_vld);
        end
        h = mk_head(2, 0, 1'b1, 1'($urandom_range(0, 1)));
        hx = h;
        hx[7:0] = 8'd1;
        bus.in_vld = 1'b1; bus.in_ftype = 2'b11; bus.in_data = h;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.out_vld !== 1'b0 || bus.out_req !== 5'b00000) begin
            errors++;
            $display("FAIL err_once: got err %b vld %b req %b expected 0 0 00000", bus.err, bus.out_vld, bus.out_req);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_req !== 5'b10000 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_next_req: got req %b err %b expected 10000 0", bus.out_req, bus.err);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== hx) begin
            errors++;
            $display("FAIL err_next_data: got vld %b data %0h expected 1 %0h", bus.out_vld, bus.out_data, hx);
        end
        @(posedge clk); #1;
        bus.out_gnt = 5'b00000;
    endtask

    task automatic test_backpressure();
        flit_t f;
        int    k;
        apply_reset();
        bus.out_rdy = 1'b0;
        bus.out_gnt = 5'b11111;
        stim_q.delete();
        f.t = 2'b01; f.d = mk_head(0, 3, 1'b0, 1'b0); stim_q.push_back(f);
        f.t = 2'b00; f.d = DW'($urandom); stim_q.push_back(f);
        f.t = 2'b00; f.d = DW'($urandom); stim_q.push_back(f);
        f.t = 2'b10; f.d = DW'($urandom); stim_q.push_back(f);
        build_expected();
        got_q.delete();
        drv_done = 1'b0;
        fork
            push_flits(1'b0);
            begin
                k = 0;
                while (!bus.out_vld && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                for (int c = 0; c < 5; c++) begin
                    checks++;
                    if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b1 || bus.out_req !== 5'b00010) begin
                        errors++;
                        $display("FAIL bp_hold cycle %0d: got rdy %b vld %b req %b expected 0 1 00010",
                                 c, bus.in_rdy, bus.out_vld, bus.out_req);
                    end
                    @(posedge clk); #1;
                end
                bus.out_rdy = 1'b1;
                for (int c = 0; c < 60 && got_q.size() < 8; c++) begin
                    if (bus.out_vld) begin
                        f.t = bus.out_ftype;
                        f.d = bus.out_data;
                        got_q.push_back(f);
                    end
                    @(posedge clk); #1;
                    if (drv_done && got_q.size() >= 4 && c > 12) break;
                end
            end
        join
        bus.out_gnt = 5'b00000;
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d flits expected 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_flit %0d: got %0h expected %0h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] h;
        bit tmo;
        apply_reset();
        bus.out_gnt = 5'b11111;
        h = mk_head(1, 0, 1'b0, 1'b0);
        bus.in_vld = 1'b1; bus.in_ftype = 2'b01; bus.in_data = h;
        @(posedge clk); #1;
        bus.in_ftype = 2'b00; bus.in_data = DW'($urandom);
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_ftype !== 2'b00 || bus.out_req !== 5'b00100) begin
            errors++;
            $display("FAIL rstmid_pre: got vld %b type %b req %b expected 1 00 00100", bus.out_vld, bus.out_ftype, bus.out_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_rdy, bus.out_vld, bus.out_req, bus.err, bus.out_ftype} !== 10'b1_0_00000_0_00 ||
            {bus.out_data, bus.dec_x, bus.dec_y} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got rdy %b vld %b req %b err %b type %b data %0h dec %0h/%0h expected 1 0 0 0 0 0 0/0",
                     bus.in_rdy, bus.out_vld, bus.out_req, bus.err, bus.out_ftype, bus.out_data, bus.dec_x, bus.dec_y);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        gen_stream(2, 1'b0);
        build_expected();
        drv_done = 1'b0;
        fork
            push_flits(1'b0);
            sink(1'b0, 1'b0, tmo);
        join
        checks++;
        if (tmo || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_count: got %0d flits (timeout %b) expected %0d", got_q.size(), tmo, exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || gotr_q[i] !== expr_q[i]) begin
                errors++;
                $display("FAIL rstmid_flit %0d: got %0h req %b expected %0h req %b", i, got_q[i], gotr_q[i], exp_q[i], expr_q[i]);
            end
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL rstmid_err: got %0d err cycles expected 0", err_seen);
        end
    endtask

    task automatic test_random();
        bit tmo;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            gen_stream(6, 1'b1);
            build_expected();
            drv_done = 1'b0;
            fork
                push_flits(1'b1);
                sink(1'b1, 1'b1, tmo);
            join
            checks++;
            if (tmo || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d flits (timeout %b) expected %0d", it, got_q.size(), tmo, exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || gotr_q[i] !== expr_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_flit %0d: got %0h req %b expected %0h req %b",
                             it, i, got_q[i], gotr_q[i], exp_q[i], expr_q[i]);
                end
            end
            checks++;
            if (err_seen != exp_err) begin
                errors++;
                $display("FAIL rand%0d_err: got %0d err cycles expected %0d", it, err_seen, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   tmo;
        flit_t f;
        apply_reset();
        stim_q.delete();
        for (int p = 0; p < 4; p++) begin
            f.t = 2'b11;
            f.d = mk_head($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stim_q.push_back(f);
        end
        build_expected();
        drv_done = 1'b0;
        fork
            push_flits(1'b0);
            sink(1'b0, 1'b0, tmo);
        join
        checks++;
        if (tmo || got_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d flits (timeout %b) expected 4", got_q.size(), tmo);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || gotr_q[i] !== expr_q[i]) begin
                errors++;
                $display("FAIL b2b_flit %0d: got %0h req %b expected %0h req %b", i, got_q[i], gotr_q[i], exp_q[i], expr_q[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_packet();
        test_single();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
